pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined WIDTH-bit adder; successor to the fixed 4-bit combinational full adder.
//  Splits the carry chain into STAGES registered slices; accepts one operand set per cycle.
//  Valid/ready on both sides; sits between operand producers and the datapath result consumer.
// PARAMETERS
//  WIDTH   16  operand/sum width in bits; must be divisible by STAGES
//  STAGES  4   pipeline depth = number of carry slices (1..WIDTH); CHUNK = WIDTH/STAGES
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand set a/b/cin valid this cycle
//  in_ready   out  1      block can accept operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  a+b+cin, modulo 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//  Reset (rst_n=0, async): all stage valid bits, sum, cout, out_valid = 0; in_ready = 1 after reset.
//  Stage k (0..STAGES-1): adds chunk k of a/b plus carry from stage k-1 (stage 0 uses cin);
//   registers the partial sum, carry out, and the not-yet-added upper chunks of a/b.
//   Completed lower chunks travel forward unchanged in delay registers.
//  Latency: exactly STAGES cycles from input handshake to out_valid (no stall). Throughput 1/cycle.
//  Handshake: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
//  Stall: adv = ~(out_valid & ~out_ready). On adv=0 every stage holds; in_ready = adv.
//   in_ready is combinational from out_valid/out_ready only, never from in_valid.
//  Bubbles are not collapsed: a stage with valid=0 still shifts when adv=1.
//  sum/cout hold stable while out_valid=1 and out_ready=0; no loss, no duplication.
//  Arithmetic: unsigned; result identical to {cout,sum} = a + b + cin at full WIDTH+1 bits.
//  Wrap-around: a=all-ones, b=0, cin=1 gives sum=0, cout=1; the carry ripples through every stage.
//  STAGES=1: single register stage, latency 1.
//  Reset mid-operation: in-flight results are discarded; the first out_valid after release
//   comes only from operands accepted after release.
// CONFIGURATION
//  Macro PIPELINED_ADDER_SUB_EN:
//   defined: extra input port sub (1b, sampled with a/b).
//    sub=1 computes a + ~b + 1 (cin ignored); cout=1 means no borrow (a>=b).
//    sub travels with its operands, so each in-flight op has its own mode.
//   undefined: no sub port; add-only behaviour as above.
// STRUCTURE
//  Package adder_pkg: CHUNK = WIDTH/STAGES calc function; typedef of the stage record
//   {valid, carry, partial sum, remaining a/b (and sub when enabled)}.
//  Sub-module adder_slice: CHUNK-bit combinational add, ports a, b, ci -> s, co;
//   instantiated STAGES times. All registers and stall logic live in pipelined_adder.
//  Elaboration check: WIDTH % STAGES != 0 is a fatal error.
// TESTING
//  T1 reset: rst_n=0 -> out_valid=0, sum=0, cout=0; after release in_ready=1 with out_ready=0.
//  T2 carry ripple (16/4): a=16'hFFFF, b=16'h0001, cin=0 -> 4 cycles later sum=16'h0000, cout=1.
//  T3 exhaustive (WIDTH=4, STAGES=2): stream all 512 a,b,cin combos back-to-back, out_ready=1
//   -> one result per cycle from cycle 2, all match the model, in order.
//  T4 backpressure: pipeline full, out_ready=0 for 5 cycles -> in_ready=0, sum/cout stable;
//   on release all results drain in order, none dropped or repeated.
//  T5 mid-op reset: 3 ops in flight, pulse rst_n low for 1 cycle -> out_valid=0 at once;
//   no stale result after release.
//  T6 (PIPELINED_ADDER_SUB_EN, 16/4): a=5, b=7, sub=1 -> sum=16'hFFFE, cout=0;
//   a=7, b=5, sub=1 -> sum=2, cout=1.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared types and helpers for the pipelined adder.
// Optional subtract mode is enabled by defining PIPELINED_ADDER_SUB_EN.
package adder_pkg;

    // Control part of every pipeline stage record
    typedef struct packed {
        logic valid;
        logic carry;
`ifdef PIPELINED_ADDER_SUB_EN
        logic sub;
`endif
    } stage_ctl_t;

    // Width of one carry slice
    function automatic int chunk_f(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: W-bit combinational add with carry in/out.
// One instance per pipeline stage.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into STAGES registered carry slices.
// Define PIPELINED_ADDER_SUB_EN to add the per-operation sub input.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CHUNK = chunk_f(WIDTH, STAGES);

    // sum fills from the top; a/b shift down so chunk k sits at bit 0
    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    logic adv;

    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_cfg
        $fatal(1, "pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    // whole pipe holds only when the result is waiting on the consumer
    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           src;
        stage_t           d_d;
        stage_t           q_q;
        logic [CHUNK-1:0] cb;
        logic [CHUNK-1:0] cs;
        logic             co;

        if (k == 0) begin : g_head
            // build the entry record from the operand ports
            always_comb begin
                src           = '0;
                src.ctl.valid = in_valid;
                src.a         = a;
                src.b         = b;
`ifdef PIPELINED_ADDER_SUB_EN
                src.ctl.sub   = sub;
                src.ctl.carry = sub ? 1'b1 : cin;
`else
                src.ctl.carry = cin;
`endif
            end
        end else begin : g_tail
            assign src = g_stage[k-1].q_q;
        end

`ifdef PIPELINED_ADDER_SUB_EN
        assign cb = src.ctl.sub ? ~src.b[CHUNK-1:0] : src.b[CHUNK-1:0];
`else
        assign cb = src.b[CHUNK-1:0];
`endif

        adder_slice #(
            .W (CHUNK)
        ) u_slice (
            .a  (src.a[CHUNK-1:0]),
            .b  (cb),
            .ci (src.ctl.carry),
            .s  (cs),
            .co (co)
        );

        // add this chunk and shift the record one slice along
        always_comb begin
            d_d           = src;
            d_d.ctl.carry = co;
            d_d.sum       = (src.sum >> CHUNK)
                          | (WIDTH'(cs) << (WIDTH - CHUNK));
            d_d.a         = src.a >> CHUNK;
            d_d.b         = src.b >> CHUNK;
        end

        // stage register, frozen while the output is stalled
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_q <= '0;
            end else if (adv) begin
                q_q <= d_d;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].q_q.ctl.valid;
    assign cout      = g_stage[STAGES-1].q_q.ctl.carry;
    assign sum       = g_stage[STAGES-1].q_q.sum;

    logic unused_tail;
`ifdef PIPELINED_ADDER_SUB_EN
    assign unused_tail = ^{g_stage[STAGES-1].q_q.a,
                           g_stage[STAGES-1].q_q.b,
                           g_stage[STAGES-1].q_q.ctl.sub};
`else
    assign unused_tail = ^{g_stage[STAGES-1].q_q.a,
                           g_stage[STAGES-1].q_q.b};
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: random and directed checks against a queue model.
// Covers both the 16/4 build and an exhaustive 4/2 instance.
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        cin, cout, sub_i;
    logic [15:0] a, b, sum;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic        cin2, cout2;
    logic [3:0]  a2, b2, sum2;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_out = 0;
    logic [16:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [16:0] held = '0;

    pipelined_adder #(
        .WIDTH  (16),
        .STAGES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    pipelined_adder #(
        .WIDTH  (4),
        .STAGES (2)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .cin       (cin2),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub       (1'b0),
`endif
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .sum       (sum2),
        .cout      (cout2)
    );

    // {cout,sum} from plain arithmetic at WIDTH+1 bits
    function automatic logic [16:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic c,
                                          input logic s);
        logic [15:0] ny;
        ny = ~y;
        if (s) return 17'(x) + 17'(ny) + 17'd1;
        return 17'(x) + 17'(y) + 17'(c);
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom % 6)
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // compare process: model queue, hold-while-stalled, ready rule
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            check("in_ready_rule", 32'(in_ready),
                  32'(!(out_valid && !out_ready)));
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_value", 32'({cout, sum}), 32'(held));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'({cout, sum}), 32'(e));
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {cout, sum};
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, cin, sub_i));
        end
    end

    task automatic send_one(input logic [15:0] xa, input logic [15:0] xb,
                            input logic xc, input logic xs,
                            output int lat, output logic [16:0] r);
        tick();
        a = xa; b = xb; cin = xc; sub_i = xs;
        in_valid = 1'b1;
        out_ready = 1'b1;
        lat = 0;
        r = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                r = {cout, sum};
                break;
            end
        end
    endtask

    task automatic drain(input string nm);
        int left;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) break;
        end
        left = exp_q.size();
        check(nm, 32'(left), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          n0;
        logic [16:0] r;
        logic [16:0] ev;
        logic [8:0]  kk;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b1;
        a2 = '0; b2 = '0; cin2 = 1'b0;

        // T1 reset
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_idle_valid", 32'(out_valid), 32'd0);

        // T2 carry ripple through all slices
        send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, r);
        check("t2_latency", 32'(lat), 32'd4);
        check("t2_sum", 32'(r[15:0]), 32'h0000);
        check("t2_cout", 32'(r[16]), 32'd1);
        send_one(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat, r);
        check("wrap_sum", 32'(r[15:0]), 32'h0000);
        check("wrap_cout", 32'(r[16]), 32'd1);
        send_one(16'h1234, 16'h4321, 1'b1, 1'b0, lat, r);
        check("lit_sum", 32'(r), 32'h05556);

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            tick();
            in_valid = ($urandom % 4) != 0;
            a = pick(); b = pick(); cin = 1'($urandom);
`ifdef PIPELINED_ADDER_SUB_EN
            sub_i = 1'($urandom);
`endif
            out_ready = ($urandom % 4) != 0;
        end
        drain("rand_drain");
        sub_i = 1'b0;

        // T4 fill, stall 5 cycles, release
        n0 = n_out;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            a = pick(); b = pick(); cin = 1'($urandom);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("t4_in_ready", 32'(in_ready), 32'd0);
            check("t4_out_valid", 32'(out_valid), 32'd1);
        end
        drain("t4_drain");
        check("t4_count", 32'(n_out - n0), 32'd4);

        // T5 reset with three ops in flight
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = pick(); b = pick(); cin = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_async_clear", 32'(out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t5_no_stale", 32'(out_valid), 32'd0);
        end
        send_one(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, lat, r);
        check("t5_fresh_lat", 32'(lat), 32'd4);
        check("t5_fresh_val", 32'(r), 32'h10000);
        drain("t5_drain");
        check("t5_count", 32'(n_out - n0), 32'd1);

`ifdef PIPELINED_ADDER_SUB_EN
        // T6 subtract mode
        send_one(16'd5, 16'd7, 1'b0, 1'b1, lat, r);
        check("t6_sum_neg", 32'(r[15:0]), 32'hFFFE);
        check("t6_cout_neg", 32'(r[16]), 32'd0);
        send_one(16'd7, 16'd5, 1'b1, 1'b1, lat, r);
        check("t6_sum_pos", 32'(r[15:0]), 32'h0002);
        check("t6_cout_pos", 32'(r[16]), 32'd1);
        drain("t6_drain");
        sub_i = 1'b0;
`endif

        // T3 exhaustive stream on the 4/2 instance
        for (int j = 0; j < 514; j++) begin
            tick();
            if (j < 512) begin
                kk = 9'(j);
                {cin2, b2, a2} = kk;
                in_valid2 = 1'b1;
            end else begin
                in_valid2 = 1'b0;
            end
            @(negedge clk);
            check("t3_in_ready", 32'(in_ready2), 32'd1);
            if (j < 2) begin
                check("t3_early", 32'(out_valid2), 32'd0);
            end else begin
                kk = 9'(j - 2);
                ev = 17'(kk[3:0]) + 17'(kk[7:4]) + 17'(kk[8]);
                check("t3_valid", 32'(out_valid2), 32'd1);
                check("t3_result", 32'({cout2, sum2}), 32'(ev));
            end
        end
        tick();
        in_valid2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t3_tail_idle", 32'(out_valid2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
